conv_mem_write_ctrl: RTL and testbench

//  Parametrised write addresser/strobe generator for a convolution layer's output memory.

---
 rtl/conv_mem_write_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_mem_write_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_write_ctrl.sv
// Output-memory write addresser for one conv layer: walks IMG_W*IMG_H pixels per channel, one strobe per pixel window.
// Optional flat address output wr_addr_lin is enabled by defining CONV_MEM_WR_LINEAR_EN.
module conv_mem_write_ctrl #(
    parameter int IMG_W          = 8,
    parameter int IMG_H          = 8,
    parameter int CHANNELS       = 3,
    parameter int CYCLES_PER_PIX = 25,
    parameter int START_DELAY    = 2,
    localparam int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr0,
    output logic [CH_W-1:0]   count,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
`ifdef CONV_MEM_WR_LINEAR_EN
    output logic [ADDR_W+CH_W-1:0] wr_addr_lin,
`endif
    output logic [1:0]        state_dbg
);

    localparam int PIX      = IMG_W * IMG_H;
    localparam int CYC_W    = (CYCLES_PER_PIX > 1) ? $clog2(CYCLES_PER_PIX) : 1;
    localparam int DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_PIX - 1);
    localparam logic [DLY_W-1:0]  DLY_END   = DLY_W'(DLY_LAST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CH_W-1:0]   count_n;
    logic [CYC_W-1:0]  cyc, cyc_n;
    logic [DLY_W-1:0]  dly, dly_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            addr0 <= '0;
            count <= '0;
            cyc   <= '0;
            dly   <= '0;
        end else begin
            state <= state_n;
            addr0 <= addr_n;
            count <= count_n;
            cyc   <= cyc_n;
            dly   <= dly_n;
        end
    end

    // wr_en is a one-cycle strobe with no back-pressure; the consumer must accept
    // the write at {count,addr0} in the cycle it is high. enable=0 stalls RUN only.
    always_comb begin
        state_n = state;
        addr_n  = addr0;
        count_n = count;
        cyc_n   = cyc;
        dly_n   = dly;
        wr_en   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    addr_n  = '0;
                    count_n = '0;
                    cyc_n   = '0;
                    dly_n   = '0;
                    state_n = (START_DELAY == 0) ? RUN : DELAY;
                end
            end
            DELAY: begin
                // Pipeline fill runs regardless of enable.
                if (dly == DLY_END) begin
                    state_n = RUN;
                    cyc_n   = '0;
                    dly_n   = '0;
                end else begin
                    dly_n = dly + DLY_W'(1);
                end
            end
            RUN: begin
                if (enable) begin
                    if (cyc == CYC_LAST) begin
                        wr_en = 1'b1;
                        cyc_n = '0;
                        if (addr0 == ADDR_LAST) begin
                            if (count == CH_LAST) begin
                                // Final address is held so it stays visible in DONE.
                                state_n = DONE;
                            end else begin
                                addr_n  = '0;
                                count_n = count + CH_W'(1);
                            end
                        end else begin
                            addr_n = addr0 + ADDR_W'(1);
                        end
                    end else begin
                        cyc_n = cyc + CYC_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state == DELAY) || (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

`ifdef CONV_MEM_WR_LINEAR_EN
    localparam int LIN_W = ADDR_W + CH_W;
    assign wr_addr_lin = LIN_W'(count) * LIN_W'(PIX) + LIN_W'(addr0);
`endif

endmodule

// File: tb/tb_conv_mem_write_ctrl.sv
// Bench for conv_mem_write_ctrl: default 8x8x3/25-cycle instance plus a 4x4x1/1-cycle instance.
// Honours CONV_MEM_WR_LINEAR_EN when defined for the flat-address check.
module tb_conv_mem_write_ctrl;
  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       start;
  logic       enable;
  logic [5:0] addr0;
  logic [1:0] count;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  logic       s_start;
  logic       s_enable;
  logic [3:0] s_addr0;
  logic [0:0] s_count;
  logic       s_wr_en;
  logic       s_busy;
  logic       s_done;
  logic [1:0] s_state_dbg;
`ifdef CONV_MEM_WR_LINEAR_EN
  logic [7:0] wr_addr_lin;
  logic [4:0] s_wr_addr_lin;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  typedef struct {
    int         edge_n;
    logic       wr_en;
    logic [5:0] addr0;
    logic [1:0] count;
    logic       busy;
    logic       done;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  conv_mem_write_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable),
    .addr0(addr0), .count(count), .wr_en(wr_en), .busy(busy), .done(done),
`ifdef CONV_MEM_WR_LINEAR_EN
    .wr_addr_lin(wr_addr_lin),
`endif
    .state_dbg(state_dbg)
  );

  conv_mem_write_ctrl #(
    .IMG_W(4), .IMG_H(4), .CHANNELS(1), .CYCLES_PER_PIX(1), .START_DELAY(0)
  ) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .enable(s_enable),
    .addr0(s_addr0), .count(s_count), .wr_en(s_wr_en), .busy(s_busy), .done(s_done),
`ifdef CONV_MEM_WR_LINEAR_EN
    .wr_addr_lin(s_wr_addr_lin),
`endif
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every strobe must match the next expected {count,addr0}
  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("extra_write", 32'd1, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("wr_addr", {24'd0, count, addr0}, {24'd0, exp_w});
      end
    end
  end

  task automatic fill_exp();
    for (int ch = 0; ch < 3; ch++)
      for (int a = 0; a < 64; a++)
        exp_q.push_back(W'(ch * 64 + a));
  endtask

  // driver: edge 0 samples start; inputs for edge e are set just after edge e-1,
  // outputs sampled at the negedge before edge e are what edge e sees.
  task automatic run_pass(input int stall_at, input int stall_len, input int start_at,
                          input int reset_at, input bit use_table);
    int last_wr;
    int first_done;
    int wr_seen;
    last_wr = -1;
    first_done = -1;
    wr_seen = 0;
    @(negedge clk);
    start = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 5200; e++) begin
      enable = !(stall_len > 0 && e >= stall_at && e < stall_at + stall_len);
      start  = (e == start_at) || (reset_at > 0 && e == reset_at + 1);
      reset  = !(reset_at > 0 && e >= reset_at && e <= reset_at + 2);
      @(negedge clk);
      if (wr_en) begin
        wr_seen++;
        last_wr = e;
      end
      if (done && first_done < 0) first_done = e;
      if (e == 1 && reset_at == 0) begin
        chk("pass_start_busy", {31'd0, busy}, 32'd1);
        chk("pass_start_done", {31'd0, done}, 32'd0);
        chk("pass_start_addr", {26'd0, addr0}, 32'd0);
        chk("pass_start_count", {30'd0, count}, 32'd0);
      end
      if (!enable) chk("stall_wr_en", {31'd0, wr_en}, 32'd0);
      for (int i = 0; i < NV; i++) begin
        if (use_table && vecs[i].edge_n == e) begin
          chk($sformatf("vec%0d_wr_en", e), {31'd0, wr_en}, {31'd0, vecs[i].wr_en});
          chk($sformatf("vec%0d_addr0", e), {26'd0, addr0}, {26'd0, vecs[i].addr0});
          chk($sformatf("vec%0d_count", e), {30'd0, count}, {30'd0, vecs[i].count});
          chk($sformatf("vec%0d_busy", e), {31'd0, busy}, {31'd0, vecs[i].busy});
          chk($sformatf("vec%0d_done", e), {31'd0, done}, {31'd0, vecs[i].done});
        end
      end
      if (reset_at > 0 && e == reset_at + 1) begin
        chk("rst_mid_outs", {26'd0, addr0, count, wr_en, busy, done}, 32'd0);
      end
      if (reset_at > 0 && e == reset_at + 4) begin
        chk("rst_start_ignored_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_ignored_done", {31'd0, done}, 32'd0);
      end
      if (reset_at > 0 && e == reset_at + 6) break;
      if (first_done >= 0 && e == first_done + 3) break;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    enable = 1'b1;
    reset = 1'b1;
    if (reset_at == 0) begin
      chk("pass_wr_count", wr_seen, 32'd192);
      chk("pass_last_wr_edge", last_wr, 4802 + stall_len);
      chk("pass_done_edge", first_done, 4803 + stall_len);
      chk("pass_q_empty", exp_q.size(), 32'd0);
      chk("pass_end_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1,    1'b0, 6'd0,  2'd0, 1'b1, 1'b0};
    vecs[1]  = '{26,   1'b0, 6'd0,  2'd0, 1'b1, 1'b0};
    vecs[2]  = '{27,   1'b1, 6'd0,  2'd0, 1'b1, 1'b0};
    vecs[3]  = '{28,   1'b0, 6'd1,  2'd0, 1'b1, 1'b0};
    vecs[4]  = '{52,   1'b1, 6'd1,  2'd0, 1'b1, 1'b0};
    vecs[5]  = '{1602, 1'b1, 6'd63, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1603, 1'b0, 6'd0,  2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1627, 1'b1, 6'd0,  2'd1, 1'b1, 1'b0};
    vecs[8]  = '{4802, 1'b1, 6'd63, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{4803, 1'b0, 6'd63, 2'd2, 1'b0, 1'b1};
    vecs[10] = '{4805, 1'b0, 6'd63, 2'd2, 1'b0, 1'b1};

    reset = 1'b0;
    start = 1'b0;
    enable = 1'b1;
    s_start = 1'b0;
    s_enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {26'd0, addr0, count, wr_en, busy, done}, 32'd0);
    chk("reset_outs_small", {25'd0, s_addr0, s_count, s_wr_en, s_busy, s_done}, 32'd0);
    reset = 1'b1;

    // single pass against the vector table
    fill_exp();
    run_pass(0, 0, 0, 0, 1'b1);

    // 10-clock stall starting mid-pixel, spanning a write cycle
    fill_exp();
    run_pass(120, 10, 0, 0, 1'b0);

    // reset at edge 1000 with a start pulse held under reset
    fill_exp();
    run_pass(0, 0, 0, 1000, 1'b0);
    exp_q.delete();
    chk("after_reset_idle", {30'd0, busy, done}, 32'd0);

    // fresh pass with start pulsed mid-RUN, then a restart from DONE
    fill_exp();
    run_pass(0, 0, 500, 0, 1'b0);
    fill_exp();
    run_pass(0, 0, 0, 0, 1'b0);

    // small instance: 16 back-to-back strobes then done
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      chk($sformatf("small_wr_en_%0d", e), {31'd0, s_wr_en}, 32'd1);
      chk($sformatf("small_addr_%0d", e), {28'd0, s_addr0}, e - 1);
      chk($sformatf("small_count_%0d", e), {31'd0, s_count}, 32'd0);
`ifdef CONV_MEM_WR_LINEAR_EN
      chk($sformatf("small_lin_%0d", e), {27'd0, s_wr_addr_lin}, {27'd0, s_count, s_addr0});
`endif
    end
    @(negedge clk);
    chk("small_end_wr_en", {31'd0, s_wr_en}, 32'd0);
    chk("small_end_done", {31'd0, s_done}, 32'd1);
    chk("small_end_busy", {31'd0, s_busy}, 32'd0);
`ifdef CONV_MEM_WR_LINEAR_EN
    chk("big_lin_final", {24'd0, wr_addr_lin}, 32'd191);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
